mem_bank_arbiter: RTL and testbench
===================================

Name: mem_bank_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for the node memory bank.
- The bank is a 64-entry, 8-bit-wide array with 16-bit big-endian word access at {mem[index], mem[index+1]}, combinational read and registered write.
- Sits between the bank and its two users: requester 0 is the RL/Q-value update engine, requester 1 is the packet/cluster handler.
- Serialises their word accesses, range-checks addresses and returns registered read data with a one-cycle acknowledge.

Parameters:
- WORD_WIDTH, 16, data/address word width (bank data_in/data_out/index width).
- MEM_DEPTH, 64, bank depth in bytes; the highest legal word index is MEM_DEPTH-2.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 access request; held high until ack0.
- we0  input  1  requester 0 write (1) / read (0).
- addr0  input  WORD_WIDTH  requester 0 byte index of the word's high byte.
- wdata0  input  WORD_WIDTH  requester 0 write data.
- ack0  output  1  one-cycle completion pulse to requester 0.
- rdata0  output  WORD_WIDTH  requester 0 read data, valid while ack0 is high.
- err0  output  1  requester 0 range error, valid while ack0 is high.
- req1, we1, addr1, wdata1, ack1, rdata1, err1: same definitions for requester 1.
- mem_wr_en  output  1  to bank wr_en.
- mem_index  output  WORD_WIDTH  to bank index.
- mem_data_in  output  WORD_WIDTH  to bank data_in.
- mem_data_out  input  WORD_WIDTH  from bank data_out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low on nrst.
- Reset state: state=IDLE, round-robin pointer last=1 (so requester 0 wins the first tie). All outputs are 0: ack*, rdata*, err*, mem_wr_en, mem_index, mem_data_in, busy.
- State machine: IDLE -> ACCESS -> RESP -> IDLE. Every access takes exactly 3 cycles. At most one access is in flight.
- IDLE:
  - Arbitrate on the current req0/req1.
  - Only one request high: grant it.
  - Both high: grant the requester that is not `last`.
  - On grant, latch owner, we, addr, wdata into internal registers. Set addr_err = (addr > MEM_DEPTH-2), unsigned compare on the full word. Update last=owner. Go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - mem_index = latched addr if !addr_err, else 0.
  - mem_data_in = latched wdata.
  - mem_wr_en = latched we & !addr_err. It is combinational from the state and latched fields, so it is high for exactly this one cycle.
  - At the clock edge, capture the response data: rdata_reg = mem_data_out for a legal read, else 0. Writes return 0.
  - Go to RESP.
- Outside ACCESS: mem_wr_en=0, mem_index=0, mem_data_in=0.
- RESP:
  - Owner's ack=1. Owner's rdata = rdata_reg. Owner's err = addr_err.
  - The non-owner's ack, rdata and err stay 0.
  - Go to IDLE.
- Latency: request seen at edge N is granted; ack is high in cycle N+2. The next grant is evaluated at edge N+3.
- Requester obligations:
  - Hold req, we, addr and wdata stable until ack. Fields are latched at grant, so later changes are ignored.
  - If req is still high in the cycle after ack, it counts as a new request.
- Fairness: with both requests held continuously, grants alternate 0,1,0,1,… and each requester waits at most one access.
- Range error: the bank is never written, and read data returns 0. Addresses 62 and below are legal at MEM_DEPTH=64, including odd (unaligned) indices.
- Reset mid-operation: nrst low asynchronously forces IDLE and drops mem_wr_en and ack immediately.
  - A write whose ACCESS edge coincides with the reset assertion is not guaranteed to be committed.
  - After reset release, no pending access is resumed.
- A request dropped before grant is simply not served. There is no abort after grant.

Test Plan:
- Single write/read: req0 we0=1 addr0=10 wdata0=16'hA55A; then read addr0=10 -> mem_wr_en is high for exactly 1 cycle with index 10; the read ack0 is in cycle N+2 with rdata0=16'hA55A and err0=0.
- Contention: req0 and req1 raised in the same cycle and held, 4 accesses -> grant order 0,1,0,1. ack1 never coincides with ack0. Each ack is separated by 3 cycles.
- Boundary: write 16'h1234 at addr 62 -> read back 16'h1234. Write at addr 63 and at addr 16'hFFFF -> err=1, mem_wr_en never asserts, rdata=0, and addr 62 still reads 16'h1234.
- Overlap/unaligned: write 16'hBEEF at 20, then 16'hCAFE at 21 -> read at 20 returns 16'hBECA.
- Reset mid-access: assert nrst low during RESP of a req1 read -> ack1, busy and mem_wr_en are 0 immediately. After release with req0 high, requester 0 is granted first.
- Held request: keep req1 high across its ack with no req0 -> back-to-back accesses with ack1 every 3 cycles. busy drops for exactly 1 cycle (IDLE) between accesses.

Source files
------------

// File: rtl/mem_bank_arbiter_if.sv
// rtl/mem_bank_arbiter_if.sv - requester and bank signal bundle for mem_bank_arbiter
interface mem_bank_arbiter_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  req0;
  logic                  we0;
  logic [WORD_WIDTH-1:0] addr0;
  logic [WORD_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic [WORD_WIDTH-1:0] rdata0;
  logic                  err0;

  logic                  req1;
  logic                  we1;
  logic [WORD_WIDTH-1:0] addr1;
  logic [WORD_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic [WORD_WIDTH-1:0] rdata1;
  logic                  err1;

  logic                  mem_wr_en;
  logic [WORD_WIDTH-1:0] mem_index;
  logic [WORD_WIDTH-1:0] mem_data_in;
  logic [WORD_WIDTH-1:0] mem_data_out;
  logic                  busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_data_out,
    output ack0, rdata0, err0,
    output ack1, rdata1, err1,
    output mem_wr_en, mem_index, mem_data_in, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_data_out,
    input  ack0, rdata0, err0,
    input  ack1, rdata1, err1,
    input  mem_wr_en, mem_index, mem_data_in, busy
  );
endinterface

// File: rtl/mem_bank_arbiter.sv
// rtl/mem_bank_arbiter.sv - two-requester round-robin arbiter and word access sequencer for the node memory bank
module mem_bank_arbiter #(
  parameter int WORD_WIDTH = 16,
  parameter int MEM_DEPTH  = 64
) (
  input logic                clk,
  input logic                nrst,
  mem_bank_arbiter_if.slave  bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [WORD_WIDTH-1:0] MAX_INDEX = WORD_WIDTH'(MEM_DEPTH - 2);

  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;

  logic                  grant_valid;
  logic                  grant_sel;
  logic [WORD_WIDTH-1:0] grant_addr;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_valid = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      grant_sel = ~last_q;
    end else begin
      grant_sel = bus.req1;
    end
    grant_addr = grant_sel ? bus.addr1 : bus.addr0;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = ST_ACCESS;
          owner_d = grant_sel;
          last_d  = grant_sel;
          we_d    = grant_sel ? bus.we1 : bus.we0;
          addr_d  = grant_addr;
          wdata_d = grant_sel ? bus.wdata1 : bus.wdata0;
          err_d   = (grant_addr > MAX_INDEX);
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        rdata_d = (!we_q && !err_q) ? bus.mem_data_out : '0;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  logic in_access;
  logic in_resp;

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  // Bank drive is decoded straight from state so reset removes it at once.
  assign bus.mem_wr_en   = in_access & we_q & ~err_q;
  assign bus.mem_index   = (in_access && !err_q) ? addr_q : '0;
  assign bus.mem_data_in = in_access ? wdata_q : '0;

  assign bus.ack0   = in_resp & ~owner_q;
  assign bus.ack1   = in_resp & owner_q;
  assign bus.rdata0 = (in_resp && !owner_q) ? rdata_q : '0;
  assign bus.rdata1 = (in_resp && owner_q) ? rdata_q : '0;
  assign bus.err0   = in_resp & ~owner_q & err_q;
  assign bus.err1   = in_resp & owner_q & err_q;
  assign bus.busy   = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_bank_arbiter.sv
// tb/tb_mem_bank_arbiter.sv - self-checking bench for mem_bank_arbiter
module tb_mem_bank_arbiter;
  logic clk;
  logic nrst;

  mem_bank_arbiter_if #(.WORD_WIDTH(16)) bus ();

  mem_bank_arbiter #(.WORD_WIDTH(16), .MEM_DEPTH(64)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: byte array, big-endian word, combinational read, registered write.
  logic [7:0] bank [64];
  logic [5:0] bidx;
  assign bidx = bus.mem_index[5:0];
  assign bus.mem_data_out = {bank[bidx], bank[bidx + 6'd1]};
  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      bank[bidx]        <= bus.mem_data_in[15:8];
      bank[bidx + 6'd1] <= bus.mem_data_in[7:0];
    end
  end

  logic [7:0] ref_mem [64];
  int checks;
  int errors;

  typedef struct {
    bit          who;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    bit          exp_err;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    if (a > 16'd62) return 16'h0000;
    return {ref_mem[a[5:0]], ref_mem[a[5:0] + 6'd1]};
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [15:0] d);
    if (a <= 16'd62) begin
      ref_mem[a[5:0]]        = d[15:8];
      ref_mem[a[5:0] + 6'd1] = d[7:0];
    end
  endtask

  // One access by one requester; k counts edges from the first edge that sees req.
  task automatic do_access(input bit who, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                           output logic [15:0] rd, output bit er, output int lat, output int pulses,
                           output logic [15:0] widx, output bit other_ack);
    bit done;
    @(posedge clk); #1;
    if (who) begin
      bus.req1 = 1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
    lat = 0; pulses = 0; done = 0; rd = 0; er = 0; widx = 0; other_ack = 0;
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (bus.mem_wr_en) begin
        pulses++;
        widx = bus.mem_index;
      end
      if (who ? bus.ack1 : bus.ack0) begin
        done = 1;
        rd = who ? bus.rdata1 : bus.rdata0;
        er = who ? bus.err1 : bus.err0;
        other_ack = who ? bus.ack0 : bus.ack1;
      end
    end
    check("access_done", {31'd0, done}, 32'd1);
    if (who) bus.req1 = 0; else bus.req0 = 0;
    if (we) ref_write(addr, wdata);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, widx;
    bit er, oack;
    int lat, pulses;

    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;

    vecs[0]  = '{0, 1, 16'd10,    16'hA55A, 16'h0000, 0, 1};
    vecs[1]  = '{0, 0, 16'd10,    16'h0000, 16'hA55A, 0, 0};
    vecs[2]  = '{1, 1, 16'd62,    16'h1234, 16'h0000, 0, 1};
    vecs[3]  = '{0, 0, 16'd62,    16'h0000, 16'h1234, 0, 0};
    vecs[4]  = '{0, 1, 16'd63,    16'h5555, 16'h0000, 1, 0};
    vecs[5]  = '{1, 1, 16'hFFFF,  16'h6666, 16'h0000, 1, 0};
    vecs[6]  = '{1, 0, 16'd62,    16'h0000, 16'h1234, 0, 0};
    vecs[7]  = '{0, 1, 16'd20,    16'hBEEF, 16'h0000, 0, 1};
    vecs[8]  = '{1, 1, 16'd21,    16'hCAFE, 16'h0000, 0, 1};
    vecs[9]  = '{0, 0, 16'd20,    16'h0000, 16'hBECA, 0, 0};
    vecs[10] = '{1, 0, 16'd63,    16'h0000, 16'h0000, 1, 0};
    vecs[11] = '{1, 0, 16'd21,    16'h0000, 16'hCAFE, 0, 0};

    // Reset values, sampled while nrst is held low.
    nrst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {26'd0, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_wr_en, bus.busy}, 32'd0);
    check("rst_rdata", {bus.rdata0, bus.rdata1}, 32'd0);
    check("rst_mem", {bus.mem_index, bus.mem_data_in}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Clear the bank through the arbiter so bank and reference start equal.
    for (int a = 0; a < 64; a += 2) begin
      do_access(a[1], 1'b1, 16'(a), 16'h0000, rd, er, lat, pulses, widx, oack);
      check("clear_err", {31'd0, er}, 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      do_access(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat, pulses, widx, oack);
      check($sformatf("vec%0d_latency", i), lat, 32'd2);
      check($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rdata});
      check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_wr_pulses", i), pulses, vecs[i].exp_pulses);
      check($sformatf("vec%0d_other_ack", i), {31'd0, oack}, 32'd0);
      if (vecs[i].exp_pulses == 1)
        check($sformatf("vec%0d_wr_index", i), {16'd0, widx}, {16'd0, vecs[i].addr});
    end

    // Contention from reset: both held, expect 0,1,0,1 every 3 cycles.
    begin
      int own [4];
      int at [4];
      int n;
      do_reset();
      @(posedge clk); #1;
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'd10;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'd62;
      n = 0;
      for (int k = 1; k <= 20 && n < 4; k++) begin
        @(posedge clk); #1;
        if (bus.ack0 && bus.ack1) check("cont_both_ack", 32'd1, 32'd0);
        if (bus.ack0 || bus.ack1) begin
          own[n] = bus.ack1 ? 1 : 0;
          at[n] = k;
          check($sformatf("cont%0d_rdata", n), {16'd0, bus.ack1 ? bus.rdata1 : bus.rdata0},
                bus.ack1 ? 32'h1234 : 32'hA55A);
          n++;
        end
      end
      drive_idle();
      check("cont_count", n, 32'd4);
      for (int j = 0; j < n; j++) begin
        check($sformatf("cont%0d_owner", j), own[j], j % 2);
        if (j > 0) check($sformatf("cont%0d_spacing", j), at[j] - at[j-1], 32'd3);
      end
      @(posedge clk);
    end

    // Held req1 alone: ack1 every 3 cycles, one idle cycle between accesses.
    begin
      int acks;
      int idles;
      int first_ack;
      @(posedge clk); #1;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'd20;
      acks = 0; idles = 0; first_ack = 0;
      for (int k = 1; k <= 11; k++) begin
        @(posedge clk); #1;
        if (!bus.busy) idles++;
        if (bus.ack1) begin
          if (acks == 0) first_ack = k;
          check($sformatf("held_ack_at%0d", k), k, first_ack + 3 * acks);
          check($sformatf("held_rdata%0d", k), {16'd0, bus.rdata1}, 32'hBECA);
          acks++;
        end
      end
      drive_idle();
      check("held_acks", acks, 32'd4);
      check("held_idle_cycles", idles, 32'd3);
      @(posedge clk);
    end

    // Reset during RESP of a req1 read; requester 0 wins the first tie afterwards.
    begin
      bit seen;
      @(posedge clk); #1;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'd62;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(posedge clk); #1;
        seen = bus.ack1;
      end
      check("rstmid_reach_resp", {31'd0, seen}, 32'd1);
      #2;
      nrst = 1'b0;
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'd20;
      #1;
      check("rstmid_ack1", {31'd0, bus.ack1}, 32'd0);
      check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
      check("rstmid_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(posedge clk); #1;
        if (bus.ack0 || bus.ack1) begin
          seen = 1;
          check("rstmid_first_owner", {30'd0, bus.ack1, bus.ack0}, 32'd1);
          check("rstmid_rdata0", {16'd0, bus.rdata0}, 32'hBECA);
        end
      end
      check("rstmid_got_ack", {31'd0, seen}, 32'd1);
      drive_idle();
    end

    // Randomized traffic against a transaction-level reference.
    begin
      bit pend [2];
      bit rwe [2];
      logic [15:0] raddr [2];
      logic [15:0] rwd [2];
      int age [2];
      logic [1:0] seen_now, seen_prev;
      bit last_m;
      int cyc, wr_cyc;
      logic [15:0] wr_idx, wr_dat;
      bit abort;

      do_reset();
      last_m = 1;
      pend[0] = 0; pend[1] = 0; age[0] = 0; age[1] = 0;
      seen_prev = 2'b00;
      wr_cyc = -10; wr_idx = 0; wr_dat = 0;
      abort = 0;
      cyc = 0;
      while (!abort && (cyc < 1500 || pend[0] || pend[1])) begin
        bit a0, a1, who, exp_owner, exp_err, exp_pulse;
        @(posedge clk); #1;
        cyc++;
        seen_now = {bus.req1, bus.req0};
        a0 = bus.ack0;
        a1 = bus.ack1;
        if (a0 || a1) begin
          check("rnd_ack_exclusive", {31'd0, a0 & a1}, 32'd0);
          who = a1;
          if (seen_prev == 2'b11) exp_owner = ~last_m;
          else exp_owner = seen_prev[1];
          check("rnd_owner", {31'd0, who}, {31'd0, exp_owner});
          last_m = exp_owner;
          exp_err = (raddr[who] > 16'd62);
          exp_pulse = rwe[who] & ~exp_err;
          check("rnd_err", {31'd0, who ? bus.err1 : bus.err0}, {31'd0, exp_err});
          check("rnd_rdata", {16'd0, who ? bus.rdata1 : bus.rdata0},
                {16'd0, rwe[who] ? 16'h0000 : ref_word(raddr[who])});
          check("rnd_other_rdata", {16'd0, who ? bus.rdata0 : bus.rdata1}, 32'd0);
          check("rnd_wr_pulse", {31'd0, wr_cyc == cyc - 1}, {31'd0, exp_pulse});
          if (exp_pulse) begin
            check("rnd_wr_index", {16'd0, wr_idx}, {16'd0, raddr[who]});
            check("rnd_wr_data", {16'd0, wr_dat}, {16'd0, rwd[who]});
            ref_write(raddr[who], rwd[who]);
          end
          pend[who] = 0;
          age[who] = 0;
        end
        if (bus.mem_wr_en) begin
          wr_cyc = cyc;
          wr_idx = bus.mem_index;
          wr_dat = bus.mem_data_in;
        end
        for (int i = 0; i < 2; i++) begin
          if (pend[i]) begin
            age[i]++;
            if (age[i] > 10) begin
              check($sformatf("rnd_starve%0d", i), age[i], 32'd10);
              abort = 1;
            end
          end else if (cyc < 1500 && $urandom_range(0, 2) != 0) begin
            int r;
            pend[i] = 1;
            rwe[i] = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 15);
            if (r == 0) raddr[i] = 16'($urandom);
            else if (r == 1) raddr[i] = 16'd63;
            else raddr[i] = 16'($urandom_range(0, 62));
            rwd[i] = 16'($urandom);
          end
        end
        bus.req0 = pend[0]; bus.we0 = rwe[0]; bus.addr0 = raddr[0]; bus.wdata0 = rwd[0];
        bus.req1 = pend[1]; bus.we1 = rwe[1]; bus.addr1 = raddr[1]; bus.wdata1 = rwd[1];
        seen_prev = seen_now;
      end
      drive_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
